// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped, time-multiplexed seven-segment controller for up to eight hex digits.
// Latency: bus access is zero-wait; seg/dp/an are registered and follow register/idx changes one edge later.
// Backpressure: none; every selected access is acknowledged combinationally in the same cycle.
module seg7_scan_ctrl #(
    parameter int          DIGITS     = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       BUS_addr,
    inout  wire  [31:0]       BUS_data,
    input  logic              BUS_req,
    inout  wire               BUS_ready,
    input  logic              BUS_RW,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);
    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    // Register file and scan state
    logic [31:0]   value_q;
    logic          mode_q;
    logic [7:0]    blank_q;
    logic [7:0]    dpm_q;
    logic [31:0]   snoop_q;
    logic [PW-1:0] pre_q;
    logic [2:0]    idx_q;

    // Output registers, already in pin polarity
    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;

    // Bus decode; addresses below BASE_ADDR wrap to large offsets and miss
    logic [31:0] offset;
    logic        sel;
    logic [31:0] rdata;

    assign offset = BUS_addr - BASE_ADDR;
    assign sel    = BUS_req && (offset < 32'd3);

    assign BUS_ready = sel ? 1'b1 : 1'bz;
    assign BUS_data  = (sel && !BUS_RW) ? rdata : 32'bz;

    // Read mux from the register contents present before the edge
    always_comb begin
        rdata = 32'h0;
        case (offset[1:0])
            2'd0:    rdata = value_q;
            2'd1:    rdata = {8'h00, dpm_q, blank_q, 7'h00, mode_q};
            2'd2:    rdata = {23'h0, mode_q, 5'h00, idx_q};
            default: rdata = 32'h0;
        endcase
    end

    // Register writes; STATUS writes are acknowledged and dropped
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            value_q <= 32'h0;
            mode_q  <= 1'b0;
            blank_q <= 8'h00;
            dpm_q   <= 8'h00;
        end else if (sel && BUS_RW) begin
            case (offset[1:0])
                2'd0: value_q <= BUS_data;
                2'd1: begin
                    mode_q  <= BUS_data[0];
                    blank_q <= BUS_data[15:8];
                    dpm_q   <= BUS_data[23:16];
                end
                default: ;
            endcase
        end
    end

    // Snoop latch captures every requested address, including our own
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            snoop_q <= 32'h0;
        else if (BUS_req)
            snoop_q <= BUS_addr;
    end

    // Prescaler and digit index; idx advances on the prescaler wrap edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre_q <= '0;
            idx_q <= 3'd0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Digit selection, blanking and hex decode (active-high codes)
    logic [31:0] src;
    logic [3:0]  nib;
    logic        blank_bit;
    logic [6:0]  seg_nx;
    logic        dp_nx;
    logic [7:0]  an_full;

    always_comb begin
        src       = mode_q ? value_q : snoop_q;
        nib       = src[{idx_q, 2'b00} +: 4];
        blank_bit = blank_q[idx_q];
        an_full   = 8'b1 << idx_q;
        dp_nx     = !blank_bit && dpm_q[idx_q];
        seg_nx    = 7'h00;
        if (!blank_bit) begin
            case (nib)
                4'h0: seg_nx = 7'h3F;
                4'h1: seg_nx = 7'h06;
                4'h2: seg_nx = 7'h5B;
                4'h3: seg_nx = 7'h4F;
                4'h4: seg_nx = 7'h66;
                4'h5: seg_nx = 7'h6D;
                4'h6: seg_nx = 7'h7D;
                4'h7: seg_nx = 7'h07;
                4'h8: seg_nx = 7'h7F;
                4'h9: seg_nx = 7'h6F;
                4'hA: seg_nx = 7'h77;
                4'hB: seg_nx = 7'h7C;
                4'hC: seg_nx = 7'h39;
                4'hD: seg_nx = 7'h5E;
                4'hE: seg_nx = 7'h79;
                default: seg_nx = 7'h71;
            endcase
        end
    end

    // Output register with polarity applied; anode and segments switch together
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg_q <= {7{ACTIVE_LOW}};
            dp_q  <= ACTIVE_LOW;
            an_q  <= {DIGITS{ACTIVE_LOW}};
        end else begin
            seg_q <= seg_nx ^ {7{ACTIVE_LOW}};
            dp_q  <= dp_nx ^ ACTIVE_LOW;
            an_q  <= an_full[DIGITS-1:0] ^ {DIGITS{ACTIVE_LOW}};
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
